// File: rtl/if_id_branch_resolve.sv
// IF/ID pipeline register with decode-stage resolution of B/BR against the fetched 2-bit prediction.
// Issues fetch redirects, squashes the wrong-path slot and counts branches and mispredicts (saturating).
module if_id_branch_resolve #(
    parameter int          CNT_W       = 16,
    parameter logic [15:0] BUBBLE_INST = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [15:0]      PC_curr,
    input  logic [15:0]      PC_next,
    input  logic [15:0]      PC_inst,
    input  logic [1:0]       prediction,
    input  logic [15:0]      predicted_target,
    input  logic [2:0]       flags,
    input  logic [15:0]      Rs_data,
    output logic [15:0]      IF_ID_PC_curr,
    output logic [15:0]      IF_ID_PC_next,
    output logic [15:0]      IF_ID_inst,
    output logic [1:0]       IF_ID_prediction,
    output logic [15:0]      IF_ID_predicted_target,
    output logic             IF_ID_valid,
    output logic             actual_taken,
    output logic [15:0]      actual_target,
    output logic             wen_BHT,
    output logic             wen_BTB,
    output logic             update_PC,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    logic [15:0]      r_pc_curr;
    logic [15:0]      r_pc_next;
    logic [15:0]      r_inst;
    logic [1:0]       r_pred;
    logic [15:0]      r_pred_tgt;
    logic             r_valid;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             w_is_b;
    logic             w_is_br;
    logic             w_br;
    logic             w_z;
    logic             w_v;
    logic             w_n;
    logic             w_cond;
    logic [15:0]      w_seq;
    logic [15:0]      w_b_off;
    logic [15:0]      w_target;
    logic             w_taken;
    logic             w_wen_bht;
    logic             w_wen_btb;
    logic             w_update_pc;

    // Flag vector is packed {Z,V,N}.
    assign w_z     = flags[2];
    assign w_v     = flags[1];
    assign w_n     = flags[0];

    assign w_is_b  = (r_inst[15:12] == 4'b1100);
    assign w_is_br = (r_inst[15:12] == 4'b1101);
    assign w_br    = r_valid & (w_is_b | w_is_br);

    // Sign-extended imm9 shifted left by one; the top sign bit falls off the 16-bit result.
    assign w_seq    = r_pc_curr + 16'd2;
    assign w_b_off  = {{6{r_inst[8]}}, r_inst[8:0], 1'b0};
    assign w_target = w_is_br ? Rs_data : (w_seq + w_b_off);

    always_comb begin
        w_cond = 1'b0;
        case (r_inst[11:9])
            3'b000: w_cond = ~w_z;
            3'b001: w_cond = w_z;
            3'b010: w_cond = ~w_z & ~w_n;
            3'b011: w_cond = w_n;
            3'b100: w_cond = w_z | (~w_z & ~w_n);
            3'b101: w_cond = w_n | w_z;
            3'b110: w_cond = w_v;
            3'b111: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    // NOTE: every output gets a default first so no path through this block can infer a latch.
    always_comb begin
        w_taken       = 1'b0;
        actual_target = w_seq;
        w_wen_bht     = 1'b0;
        w_wen_btb     = 1'b0;
        w_update_pc   = 1'b0;
        if (!stall) begin
            if (w_br) begin
                w_wen_bht     = 1'b1;
                w_taken       = w_cond;
                actual_target = w_cond ? w_target : w_seq;
                w_wen_btb     = w_cond;
                w_update_pc   = (w_cond != r_pred[1]) |
                                (w_cond & r_pred[1] & (r_pred_tgt != w_target));
            end else if (r_valid && r_pred[1]) begin
                // Non-branch that fetch predicted taken: redirect to the sequential PC and retrain.
                w_wen_bht   = 1'b1;
                w_update_pc = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_curr  <= 16'h0000;
            r_pc_next  <= 16'h0000;
            r_inst     <= BUBBLE_INST;
            r_pred     <= 2'b00;
            r_pred_tgt <= 16'h0000;
            r_valid    <= 1'b0;
        end else if (!stall) begin
            if (w_update_pc) begin
                r_pc_curr  <= 16'h0000;
                r_pc_next  <= 16'h0000;
                r_inst     <= BUBBLE_INST;
                r_pred     <= 2'b00;
                r_pred_tgt <= 16'h0000;
                r_valid    <= 1'b0;
            end else begin
                r_pc_curr  <= PC_curr;
                r_pc_next  <= PC_next;
                r_inst     <= PC_inst;
                r_pred     <= prediction;
                r_pred_tgt <= predicted_target;
                r_valid    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_br && !stall && !(&r_branch_cnt)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_update_pc && !(&r_mispred_cnt)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign IF_ID_PC_curr          = r_pc_curr;
    assign IF_ID_PC_next          = r_pc_next;
    assign IF_ID_inst             = r_inst;
    assign IF_ID_prediction       = r_pred;
    assign IF_ID_predicted_target = r_pred_tgt;
    assign IF_ID_valid            = r_valid;
    assign actual_taken           = w_taken;
    assign wen_BHT                = w_wen_bht;
    assign wen_BTB                = w_wen_btb;
    assign update_PC              = w_update_pc;
    assign branch_count           = r_branch_cnt;
    assign mispredict_count       = r_mispred_cnt;

endmodule
